// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct encodings, ALU op, writeback select and decode control types
package mips_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_GPIO_RD = 6'h23;
  localparam logic [5:0] OP_GPIO_WR = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [3:0] {
    ALU_AND   = 4'd0,
    ALU_OR    = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_NOR   = 4'd3,
    ALU_ADD   = 4'd4,
    ALU_SUB   = 4'd5,
    ALU_SLT   = 4'd6,
    ALU_SLTU  = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_LUI   = 4'd11,
    ALU_MULT  = 4'd12,
    ALU_MULTU = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'd0,
    SEL_HI   = 2'd1,
    SEL_LO   = 2'd2,
    SEL_GPIO = 2'd3
  } regsel_e;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_SIGN = 2'd1,
    IMM_ZERO = 2'd2
  } imm_ext_e;

  typedef struct packed {
    alu_op_e  alu_op;
    regsel_e  regsel;
    imm_ext_e imm_ext;
    logic     regwrite;
    logic     dest_rt;
    logic     hilo_write;
    logic     gpio_write;
    logic     is_beq;
    logic     is_bne;
  } ctrl_t;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input imm_ext_e sel);
    logic [31:0] r;
    case (sel)
      IMM_SIGN: r = {{16{imm[15]}}, imm};
      IMM_ZERO: r = {16'h0000, imm};
      default:  r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - combinational ALU: logic, add/sub, compares, shifts, lui, 32x32 multiply
module mips_alu
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e          op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [4:0]       shamt_i,
  output logic [XLEN-1:0]  lo_o,
  output logic [XLEN-1:0]  hi_o,
  output logic             zero_o
);

  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] prod;
  logic              sext;

  // One multiplier serves both mult and multu; the low 2*XLEN bits of the
  // product of the extended operands are exact for either signedness.
  assign sext  = (op_i == ALU_MULT);
  assign a_ext = {{XLEN{sext & a_i[XLEN-1]}}, a_i};
  assign b_ext = {{XLEN{sext & b_i[XLEN-1]}}, b_i};
  assign prod  = a_ext * b_ext;

  always_comb begin
    lo_o = '0;
    hi_o = '0;
    case (op_i)
      ALU_AND:   lo_o = a_i & b_i;
      ALU_OR:    lo_o = a_i | b_i;
      ALU_XOR:   lo_o = a_i ^ b_i;
      ALU_NOR:   lo_o = ~(a_i | b_i);
      ALU_ADD:   lo_o = a_i + b_i;
      ALU_SUB:   lo_o = a_i - b_i;
      ALU_SLT:   lo_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU:  lo_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      ALU_SLL:   lo_o = b_i << shamt_i;
      ALU_SRL:   lo_o = b_i >> shamt_i;
      ALU_SRA:   lo_o = $unsigned($signed(b_i) >>> shamt_i);
      ALU_LUI:   lo_o = b_i << 16;
      ALU_MULT,
      ALU_MULTU: {hi_o, lo_o} = prod;
      default:   lo_o = '0;
    endcase
  end

  assign zero_o = (lo_o == '0);

endmodule

// File: rtl/mips_ex_datapath.sv
// rtl/mips_ex_datapath.sv - EX/WB stage: decode, regfile, ALU, HI/LO, GPIO; REGFILE_BYPASS_EN forwards writedata_wb
module mips_ex_datapath
  import mips_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_ex,
  input  logic [XLEN-1:0] gpio_in,
  output logic [XLEN-1:0] gpio_out,
  output logic            branch_taken,
  output logic [11:0]     branch_offset
);

  localparam int AW = $clog2(NREG);

  logic [5:0]    op, funct;
  logic [AW-1:0] rs, rt, rd, dest;
  logic [4:0]    shamt;
  ctrl_t         ctrl;

  assign op    = instr_ex[31:26];
  assign rs    = instr_ex[21 +: AW];
  assign rt    = instr_ex[16 +: AW];
  assign rd    = instr_ex[11 +: AW];
  assign shamt = instr_ex[10:6];
  assign funct = instr_ex[5:0];

  always_comb begin
    ctrl = '0;
    case (op)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        case (funct)
          F_ADD, F_ADDU: ctrl.alu_op = ALU_ADD;
          F_SUB, F_SUBU: ctrl.alu_op = ALU_SUB;
          F_AND:   ctrl.alu_op = ALU_AND;
          F_OR:    ctrl.alu_op = ALU_OR;
          F_XOR:   ctrl.alu_op = ALU_XOR;
          F_NOR:   ctrl.alu_op = ALU_NOR;
          F_SLT:   ctrl.alu_op = ALU_SLT;
          F_SLTU:  ctrl.alu_op = ALU_SLTU;
          F_SLL:   ctrl.alu_op = ALU_SLL;
          F_SRL:   ctrl.alu_op = ALU_SRL;
          F_SRA:   ctrl.alu_op = ALU_SRA;
          F_MFHI:  ctrl.regsel = SEL_HI;
          F_MFLO:  ctrl.regsel = SEL_LO;
          F_MULT:  begin ctrl.alu_op = ALU_MULT;  ctrl.regwrite = 1'b0; ctrl.hilo_write = 1'b1; end
          F_MULTU: begin ctrl.alu_op = ALU_MULTU; ctrl.regwrite = 1'b0; ctrl.hilo_write = 1'b1; end
          default: ctrl.regwrite = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin ctrl.alu_op = ALU_ADD;  ctrl.imm_ext = IMM_SIGN; ctrl.regwrite = 1'b1; ctrl.dest_rt = 1'b1; end
      OP_SLTI:  begin ctrl.alu_op = ALU_SLT;  ctrl.imm_ext = IMM_SIGN; ctrl.regwrite = 1'b1; ctrl.dest_rt = 1'b1; end
      OP_SLTIU: begin ctrl.alu_op = ALU_SLTU; ctrl.imm_ext = IMM_SIGN; ctrl.regwrite = 1'b1; ctrl.dest_rt = 1'b1; end
      OP_ANDI:  begin ctrl.alu_op = ALU_AND;  ctrl.imm_ext = IMM_ZERO; ctrl.regwrite = 1'b1; ctrl.dest_rt = 1'b1; end
      OP_ORI:   begin ctrl.alu_op = ALU_OR;   ctrl.imm_ext = IMM_ZERO; ctrl.regwrite = 1'b1; ctrl.dest_rt = 1'b1; end
      OP_XORI:  begin ctrl.alu_op = ALU_XOR;  ctrl.imm_ext = IMM_ZERO; ctrl.regwrite = 1'b1; ctrl.dest_rt = 1'b1; end
      OP_LUI:   begin ctrl.alu_op = ALU_LUI;  ctrl.imm_ext = IMM_ZERO; ctrl.regwrite = 1'b1; ctrl.dest_rt = 1'b1; end
      OP_GPIO_RD: begin ctrl.regsel = SEL_GPIO; ctrl.regwrite = 1'b1; ctrl.dest_rt = 1'b1; end
      OP_GPIO_WR: ctrl.gpio_write = 1'b1;
      OP_BEQ:   begin ctrl.alu_op = ALU_SUB; ctrl.is_beq = 1'b1; end
      OP_BNE:   begin ctrl.alu_op = ALU_SUB; ctrl.is_bne = 1'b1; end
      default:  ctrl = '0;
    endcase
  end

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] hi_q, lo_q, gpio_q;
  logic            regwrite_wb_q, regwrite_wb_d;
  logic [AW-1:0]   writeaddr_wb_q;
  logic [XLEN-1:0] writedata_wb_q, writedata_wb_d;
  logic [XLEN-1:0] rs_data, rt_data, alu_b, alu_lo, alu_hi;
  logic            alu_zero;

`ifdef REGFILE_BYPASS_EN
  assign rs_data = (regwrite_wb_q && writeaddr_wb_q != '0 && writeaddr_wb_q == rs) ? writedata_wb_q : regs_q[rs];
  assign rt_data = (regwrite_wb_q && writeaddr_wb_q != '0 && writeaddr_wb_q == rt) ? writedata_wb_q : regs_q[rt];
`else
  assign rs_data = regs_q[rs];
  assign rt_data = regs_q[rt];
`endif

  assign alu_b = (ctrl.imm_ext == IMM_NONE) ? rt_data : extend_imm(instr_ex[15:0], ctrl.imm_ext);

  mips_alu #(.XLEN(XLEN)) u_alu (
    .op_i    (ctrl.alu_op),
    .a_i     (rs_data),
    .b_i     (alu_b),
    .shamt_i (shamt),
    .lo_o    (alu_lo),
    .hi_o    (alu_hi),
    .zero_o  (alu_zero)
  );

  assign dest          = ctrl.dest_rt ? rt : rd;
  assign regwrite_wb_d = ctrl.regwrite && (dest != '0);

  always_comb begin
    writedata_wb_d = alu_lo;
    case (ctrl.regsel)
      SEL_HI:   writedata_wb_d = hi_q;
      SEL_LO:   writedata_wb_d = lo_q;
      SEL_GPIO: writedata_wb_d = gpio_in;
      default:  writedata_wb_d = alu_lo;
    endcase
  end

  assign branch_taken  = (ctrl.is_beq & alu_zero) | (ctrl.is_bne & ~alu_zero);
  assign branch_offset = instr_ex[11:0];
  assign gpio_out      = gpio_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_wb_q  <= 1'b0;
      writeaddr_wb_q <= '0;
      writedata_wb_q <= '0;
      hi_q           <= '0;
      lo_q           <= '0;
      gpio_q         <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regwrite_wb_q  <= regwrite_wb_d;
      writeaddr_wb_q <= dest;
      writedata_wb_q <= writedata_wb_d;
      if (ctrl.hilo_write) begin
        hi_q <= alu_hi;
        lo_q <= alu_lo;
      end
      if (ctrl.gpio_write) gpio_q <= rt_data;
      if (regwrite_wb_q && writeaddr_wb_q != '0) regs_q[writeaddr_wb_q] <= writedata_wb_q;
    end
  end

endmodule

// File: tb/tb_mips_ex_datapath.sv
// tb/tb_mips_ex_datapath.sv - directed bench with an architectural ISA model for mips_ex_datapath
module tb_mips_ex_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_ex = 32'h0;
  logic [31:0] gpio_in = 32'h0;
  logic [31:0] gpio_out;
  logic        branch_taken;
  logic [11:0] branch_offset;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_reg [32];
  logic [31:0] m_hi, m_lo, m_gpio;

  mips_ex_datapath #(.XLEN(32), .NREG(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_ex      (instr_ex),
    .gpio_in       (gpio_in),
    .gpio_out      (gpio_out),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0; m_gpio = 32'h0;
  endtask

  task automatic wr(input int d, input logic [31:0] v);
    if (d != 0) m_reg[d] = v;
  endtask

  function automatic logic model_branch(input logic [31:0] ins);
    logic [31:0] a, b;
    a = m_reg[ins[25:21]];
    b = m_reg[ins[20:16]];
    if (ins[31:26] == 6'h04) return a == b;
    if (ins[31:26] == 6'h05) return a != b;
    return 1'b0;
  endfunction

  // Architectural effect of one instruction, applied when it leaves EX.
  task automatic model_exec(input logic [31:0] ins);
    logic [31:0] a, b, simm, zimm;
    logic [63:0] p;
    int rt, rd, sh;
    a = m_reg[ins[25:21]];
    b = m_reg[ins[20:16]];
    rt = int'(ins[20:16]);
    rd = int'(ins[15:11]);
    sh = int'(ins[10:6]);
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0, ins[15:0]};
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20, 6'h21: wr(rd, a + b);
        6'h22, 6'h23: wr(rd, a - b);
        6'h24: wr(rd, a & b);
        6'h25: wr(rd, a | b);
        6'h26: wr(rd, a ^ b);
        6'h27: wr(rd, ~(a | b));
        6'h2A: wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        6'h2B: wr(rd, (a < b) ? 32'd1 : 32'd0);
        6'h00: wr(rd, b << sh);
        6'h02: wr(rd, b >> sh);
        6'h03: wr(rd, $unsigned($signed(b) >>> sh));
        6'h18: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
        6'h19: begin p = {32'h0, a} * {32'h0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
        6'h10: wr(rd, m_hi);
        6'h12: wr(rd, m_lo);
        default: ;
      endcase
      6'h08, 6'h09: wr(rt, a + simm);
      6'h0A: wr(rt, ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0);
      6'h0B: wr(rt, (a < simm) ? 32'd1 : 32'd0);
      6'h0C: wr(rt, a & zimm);
      6'h0D: wr(rt, a | zimm);
      6'h0E: wr(rt, a ^ zimm);
      6'h0F: wr(rt, {ins[15:0], 16'h0});
      6'h23: wr(rt, gpio_in);
      6'h2B: m_gpio = b;
      default: ;
    endcase
  endtask

  // Inputs change 1 time unit after the rising edge; the model retires at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_exec(instr_ex);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input int nops);
    instr_ex = ins;
    tick();
    for (int i = 0; i < nops; i++) begin
      instr_ex = 32'h0;
      tick();
    end
  endtask

  task automatic show(input int r, input string name, input logic [31:0] exp);
    issue(itype(6'h2B, 0, r, 0), 1);
    chk({name, "_dut"}, gpio_out, exp);
    chk({name, "_model"}, m_gpio, exp);
  endtask

  task automatic br(input logic [31:0] ins, input logic exp_bt, input string name);
    instr_ex = ins;
    #1;
    chk({name, "_taken"}, {31'h0, branch_taken}, {31'h0, exp_bt});
    chk({name, "_offset"}, {20'h0, branch_offset}, {20'h0, ins[11:0]});
    tick();
    instr_ex = 32'h0;
    tick();
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("cyc_gpio_out", gpio_out, m_gpio);
      chk("cyc_branch_taken", {31'h0, branch_taken}, {31'h0, model_branch(instr_ex)});
      chk("cyc_branch_offset", {20'h0, branch_offset}, {20'h0, instr_ex[11:0]});
    end
  end

  int fl [10] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
  int il [5]  = '{'h08, 'h0A, 'h0B, 'h0C, 'h0E};

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 4; i++) issue(32'h0, 0);
    chk("reset_gpio", gpio_out, 32'h0);
    chk("reset_bt", {31'h0, branch_taken}, 32'h0);

    issue(itype('h08, 0, 1, 5), 1);
    issue(itype('h08, 0, 2, -3), 1);
    issue(rtype(1, 2, 3, 0, 'h20), 1);
    show(3, "add_r3", 32'd2);
    issue(rtype(2, 1, 4, 0, 'h22), 1);
    show(4, "sub_r4", 32'hFFFF_FFF8);
    issue(rtype(1, 2, 5, 0, 'h2B), 1);
    show(5, "sltu_r5", 32'd1);
    issue(rtype(1, 2, 6, 0, 'h2A), 1);
    show(6, "slt_r6", 32'd0);

    issue(itype('h0F, 0, 1, 'h0001), 1);
    issue(rtype(1, 1, 0, 0, 'h18), 0);
    issue(rtype(0, 0, 7, 0, 'h10), 1);
    show(7, "mult_hi", 32'd1);
    issue(rtype(0, 0, 9, 0, 'h12), 1);
    show(9, "mult_lo", 32'd0);
    issue(itype('h08, 0, 10, -1), 1);
    issue(itype('h08, 0, 11, 2), 1);
    issue(rtype(10, 11, 0, 0, 'h19), 0);
    issue(rtype(0, 0, 12, 0, 'h10), 0);
    issue(rtype(0, 0, 13, 0, 'h12), 1);
    show(12, "multu_hi", 32'd1);
    show(13, "multu_lo", 32'hFFFF_FFFE);

    gpio_in = 32'hA5A5_A5A5;
    issue(itype('h23, 0, 8, 0), 1);
    gpio_in = 32'h0;
    show(8, "gpio_loop", 32'hA5A5_A5A5);

    issue(itype('h0D, 0, 1, 'h8000), 1);
    show(1, "ori_r1", 32'h0000_8000);
    issue(itype('h0F, 0, 14, 'h8000), 1);
    issue(rtype(0, 14, 15, 4, 'h03), 1);
    show(15, "sra_r15", 32'hF800_0000);
    issue(itype('h08, 0, 0, 7), 1);
    issue(rtype(1, 1, 0, 0, 'h20), 1);
    show(0, "r0_zero", 32'h0);

    br(itype('h04, 1, 1, 'h005), 1'b1, "beq_eq");
    br(itype('h05, 1, 1, 'h005), 1'b0, "bne_eq");
    br(itype('h05, 1, 0, 'hFFF), 1'b1, "bne_ne");
    br(itype('h04, 1, 0, 'h123), 1'b0, "beq_ne");

    issue(itype('h0F, 0, 20, 'h8F0F), 1);
    issue(itype('h0D, 20, 20, 'h1234), 1);
    issue(itype('h08, 0, 21, -100), 1);
    foreach (fl[k]) begin
      issue(rtype(20, 21, 22, 0, fl[k]), 1);
      issue(itype('h2B, 0, 22, 0), 1);
    end
    issue(rtype(0, 20, 22, 7, 'h00), 1);
    issue(itype('h2B, 0, 22, 0), 1);
    issue(rtype(0, 20, 22, 7, 'h02), 1);
    issue(itype('h2B, 0, 22, 0), 1);
    foreach (il[k]) begin
      issue(itype(il[k], 20, 22, 'h8001), 1);
      issue(itype('h2B, 0, 22, 0), 1);
    end
    issue(32'hFC00_0000, 1);
    issue(rtype(1, 2, 3, 0, 'h3F), 1);
    show(3, "illegal_nop", 32'd2);

    issue(itype('h08, 0, 1, 5), 1);
    issue(itype('h08, 0, 2, -3), 1);
    issue(rtype(1, 2, 3, 0, 'h20), 1);
    show(3, "add_again", 32'd2);
    issue(itype('h2B, 0, 14, 0), 0);
    issue(itype('h08, 0, 1, 9), 0);
    chk("pre_reset_gpio", gpio_out, 32'h8000_0000);
    #2 rst = 1'b1;
    model_reset();
    instr_ex = 32'h0;
    #1 chk("async_reset_gpio", gpio_out, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    show(1, "reset_r1", 32'h0);
    show(3, "reset_r3", 32'h0);
    issue(rtype(0, 0, 7, 0, 'h10), 1);
    show(7, "reset_hi", 32'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
